rst_seq_ctrl: RTL
=================

// Module: rst_seq_ctrl
// PURPOSE
//   Parametrised reset sequencer for multi-domain designs. Drives the PLL reset, qualifies lock
//   and releases NUM_CH active-low domain resets in fixed order, STAGE_GAP cycles apart.
//   Detects lock loss and lock timeout, retries the PLL up to MAX_RETRY times, then flags a
//   sticky fault. Sits between the board reset/PLL and every downstream block's reset input.
// PARAMETERS
//   NUM_CH        4      number of sequenced reset outputs, 1..16
//   PLL_RST_CYC   16     cycles pll_areset is held high per PLL reset attempt, >=1
//   LOCK_STABLE   64     consecutive synced-lock cycles needed to qualify lock, >=1
//   LOCK_TIMEOUT  65536  cycles allowed in WAIT_LOCK before an attempt fails, >LOCK_STABLE
//   STAGE_GAP     8      cycles between successive channel releases, >=1
//   MAX_RETRY     3      failed lock attempts tolerated before FAULT, >=1
// PORTS
//   clk          in   1       free-running reference clock
//   rst          in   1       synchronous, active-high reset
//   pll_locked   in   1       PLL lock, asynchronous to clk; 2-flop synchronised internally
//   soft_rst_req in   1       single-cycle request to re-run channel release without PLL reset
//   pll_areset   out  1       PLL reset, active high
//   ch_rst_n     out  NUM_CH  domain resets, active low; bit 0 released first
//   all_ready    out  1       high in RUN only
//   fault        out  1       sticky lock failure, cleared by rst only
//   retry_cnt    out  clog2(MAX_RETRY+1)  failed attempts since last RUN
// BEHAVIOUR
//   Reset (rst=1): state=PLL_RST, counters=0, pll_areset=1, ch_rst_n=0, all_ready=0, fault=0,
//     retry_cnt=0. All outputs are registered.
//   lock_s = pll_locked after 2 flops; all lock decisions use lock_s.
//   PLL_RST:   pll_areset=1 for exactly PLL_RST_CYC cycles (counting from the first clk edge
//     with rst=0), then go to WAIT_LOCK with pll_areset=0.
//   WAIT_LOCK: tmo counter counts every cycle; stable counter counts consecutive lock_s=1 and
//     clears on lock_s=0. stable==LOCK_STABLE -> RELEASE. tmo==LOCK_TIMEOUT -> retry_cnt+1;
//     if the new retry_cnt==MAX_RETRY -> FAULT, else -> PLL_RST. Qualification wins if both
//     occur in the same cycle.
//   RELEASE: gap counter from 0 on entry; ch_rst_n[k] goes 1 at entry+(k+1)*STAGE_GAP cycles.
//     Released bits stay 1. After bit NUM_CH-1 -> RUN on the next cycle.
//   RUN: all_ready=1, retry_cnt cleared on entry.
//   Lock loss (lock_s=0 for 1 cycle in RELEASE or RUN): next cycle ch_rst_n=0, all_ready=0,
//     -> PLL_RST. retry_cnt is unchanged.
//   soft_rst_req in RELEASE/RUN: next cycle ch_rst_n=0, all_ready=0, -> RELEASE with the gap
//     counter restarted. Ignored in PLL_RST, WAIT_LOCK and FAULT. Lock loss has priority
//     over soft_rst_req.
//   FAULT: pll_areset=1, ch_rst_n=0, all_ready=0, fault=1. Exit only by rst.
//   rst in any state returns to reset values on the next edge, including mid-RELEASE.
//   Counters are sized to the largest parameter they must reach; no wrap is reachable.
// TESTING (NUM_CH=3, PLL_RST_CYC=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, STAGE_GAP=4, MAX_RETRY=2)
//   Nominal: pll_locked=1 throughout -> pll_areset high 4 cycles; ch_rst_n goes 001,011,111
//     at 4/8/12 cycles after qualification; all_ready=1 one cycle after 111.
//   Glitchy lock: lock toggles every 5 cycles, then holds -> no release until 8 consecutive
//     lock_s; release timing as in Nominal from that point.
//   Timeout/fault: pll_locked=0 -> two 32-cycle WAIT_LOCK windows, each preceded by 4-cycle
//     pll_areset; retry_cnt goes 1 then 2; fault=1, pll_areset stuck 1; fault clears only
//     after rst.
//   Lock loss in RUN: drop pll_locked 1 cycle -> ch_rst_n=000 within 3 cycles of the drop,
//     pll_areset pulses 4 cycles, full sequence repeats, retry_cnt stays 0.
//   Soft reset: soft_rst_req pulse in RUN -> ch_rst_n=000 next cycle, pll_areset stays 0,
//     re-release at 4/8/12; same-cycle lock loss -> PLL_RST path taken instead.
//   Reset mid-RELEASE: assert rst when ch_rst_n=011 -> next edge all reset values,
//     sequence restarts from PLL_RST.

Source files
------------

// File: rtl/rst_seq_ctrl_if.sv
// Bundle of the sequencer's PLL-side and domain-side signals.
// The master drives lock status and soft reset requests; the slave (the sequencer)
// drives the PLL reset, the domain resets and the status flags.
interface rst_seq_ctrl_if #(
   parameter int NUM_CH  = 4,
   parameter int RETRY_W = 2
);
   logic                pll_locked;
   logic                soft_rst_req;
   logic                pll_areset;
   logic [NUM_CH-1:0]   ch_rst_n;
   logic                all_ready;
   logic                fault;
   logic [RETRY_W-1:0]  retry_cnt;

   modport master (
      output pll_locked, soft_rst_req,
      input  pll_areset, ch_rst_n, all_ready, fault, retry_cnt
   );

   modport slave (
      input  pll_locked, soft_rst_req,
      output pll_areset, ch_rst_n, all_ready, fault, retry_cnt
   );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: pulses the PLL reset, qualifies a stable lock, then releases the
// active-low domain resets one by one, STAGE_GAP cycles apart. Lock loss restarts the
// PLL, repeated lock timeouts end in a sticky fault that only rst clears.
module rst_seq_ctrl #(
   parameter int NUM_CH       = 4,
   parameter int PLL_RST_CYC  = 16,
   parameter int LOCK_STABLE  = 64,
   parameter int LOCK_TIMEOUT = 65536,
   parameter int STAGE_GAP    = 8,
   parameter int MAX_RETRY    = 3
) (
   input  logic          clk,
   input  logic          rst,
   rst_seq_ctrl_if.slave io_bus
);
   localparam int RETRY_W = $clog2(MAX_RETRY + 1);
   localparam int MAX_AB  = (PLL_RST_CYC > LOCK_TIMEOUT) ? PLL_RST_CYC : LOCK_TIMEOUT;
   localparam int CNT_MAX = (MAX_AB > STAGE_GAP) ? MAX_AB : STAGE_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int STB_W   = $clog2(LOCK_STABLE + 1);

   typedef enum logic [2:0] {
      S_PLL_RST,
      S_WAIT_LOCK,
      S_RELEASE,
      S_RUN,
      S_FAULT
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [STB_W-1:0]    r_stable;
   logic                r_lockMeta;
   logic                r_lockSync;
   logic                r_pllAreset;
   logic [NUM_CH-1:0]   r_chRstN;
   logic                r_allReady;
   logic                r_fault;
   logic [RETRY_W-1:0]  r_retryCnt;

   logic                w_lockS;
   logic [CNT_W-1:0]    w_cntInc;
   logic [STB_W-1:0]    w_stableInc;
   logic [RETRY_W-1:0]  w_retryInc;
   logic [NUM_CH-1:0]   w_chShift;

   assign w_lockS     = r_lockSync;
   assign w_cntInc    = r_cnt + CNT_W'(1);
   assign w_stableInc = r_stable + STB_W'(1);
   assign w_retryInc  = r_retryCnt + RETRY_W'(1);
   // Shifting a one in from the bottom releases channels strictly in bit order.
   assign w_chShift   = (r_chRstN << 1) | NUM_CH'(1);

   // Two-flop synchroniser for the asynchronous PLL lock; left unreset so it keeps tracking through rst.
   always_ff @(posedge clk) begin
      r_lockMeta <= io_bus.pll_locked;
      r_lockSync <= r_lockMeta;
   end

   // Sequencer FSM with all outputs registered; one shared counter serves PLL hold, lock timeout and release gaps.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_PLL_RST;
         r_cnt       <= '0;
         r_stable    <= '0;
         r_pllAreset <= 1'b1;
         r_chRstN    <= '0;
         r_allReady  <= 1'b0;
         r_fault     <= 1'b0;
         r_retryCnt  <= '0;
      end else begin
         case (r_state)
            S_PLL_RST: begin
               if (r_cnt == CNT_W'(PLL_RST_CYC - 1)) begin
                  r_state     <= S_WAIT_LOCK;
                  r_pllAreset <= 1'b0;
                  r_cnt       <= '0;
                  r_stable    <= '0;
               end else begin
                  r_cnt <= w_cntInc;
               end
            end
            S_WAIT_LOCK: begin
               if (w_lockS && (w_stableInc == STB_W'(LOCK_STABLE))) begin
                  r_state <= S_RELEASE;
                  r_cnt   <= '0;
               end else if (w_cntInc == CNT_W'(LOCK_TIMEOUT)) begin
                  r_retryCnt  <= w_retryInc;
                  r_cnt       <= '0;
                  r_pllAreset <= 1'b1;
                  if (w_retryInc == RETRY_W'(MAX_RETRY)) begin
                     r_state <= S_FAULT;
                     r_fault <= 1'b1;
                  end else begin
                     r_state <= S_PLL_RST;
                  end
               end else begin
                  r_cnt    <= w_cntInc;
                  r_stable <= w_lockS ? w_stableInc : '0;
               end
            end
            S_RELEASE: begin
               if (!w_lockS) begin
                  r_state     <= S_PLL_RST;
                  r_pllAreset <= 1'b1;
                  r_chRstN    <= '0;
                  r_cnt       <= '0;
               end else if (io_bus.soft_rst_req) begin
                  r_chRstN <= '0;
                  r_cnt    <= '0;
               end else if (&r_chRstN) begin
                  r_state    <= S_RUN;
                  r_allReady <= 1'b1;
                  r_retryCnt <= '0;
               end else if (r_cnt == CNT_W'(STAGE_GAP - 1)) begin
                  r_chRstN <= w_chShift;
                  r_cnt    <= '0;
               end else begin
                  r_cnt <= w_cntInc;
               end
            end
            S_RUN: begin
               if (!w_lockS) begin
                  r_state     <= S_PLL_RST;
                  r_pllAreset <= 1'b1;
                  r_chRstN    <= '0;
                  r_allReady  <= 1'b0;
                  r_cnt       <= '0;
               end else if (io_bus.soft_rst_req) begin
                  r_state    <= S_RELEASE;
                  r_chRstN   <= '0;
                  r_allReady <= 1'b0;
                  r_cnt      <= '0;
               end
            end
            S_FAULT: begin
               r_pllAreset <= 1'b1;
               r_chRstN    <= '0;
               r_allReady  <= 1'b0;
               r_fault     <= 1'b1;
            end
            default: begin
               r_state     <= S_PLL_RST;
               r_pllAreset <= 1'b1;
               r_chRstN    <= '0;
               r_allReady  <= 1'b0;
               r_cnt       <= '0;
            end
         endcase
      end
   end

   assign io_bus.pll_areset = r_pllAreset;
   assign io_bus.ch_rst_n   = r_chRstN;
   assign io_bus.all_ready  = r_allReady;
   assign io_bus.fault      = r_fault;
   assign io_bus.retry_cnt  = r_retryCnt;
endmodule
